// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared constants, fetch FSM states and address helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int LARGURA_PALAVRA = 32;
  localparam logic [LARGURA_PALAVRA-1:0] PC_RESET = 32'h0000_0000;
  localparam int PASSO_PC = 4;

  typedef enum logic [0:0] {
    REQUISITA = 1'b0,
    SEGURA    = 1'b1
  } estado_busca_t;

  function automatic logic [LARGURA_PALAVRA-1:0] alinha_palavra(
    input logic [LARGURA_PALAVRA-1:0] addr
  );
    return addr & ~LARGURA_PALAVRA'(3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/registrador_pc.sv
`default_nettype none
// ============================================================================
// Module   : registrador_pc
// Brief    : Program counter with synchronous reset, load and increment.
// Revision : 1.0 - initial release
// ============================================================================
module registrador_pc #(
  parameter int                 LARGURA  = mips_pkg::LARGURA_PALAVRA,
  parameter logic [LARGURA-1:0] PC_RESET = '0,
  parameter int                 PASSO    = mips_pkg::PASSO_PC
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carrega,
  input  logic [LARGURA-1:0] alvo,
  input  logic               incrementa,
  output logic [LARGURA-1:0] pc
);

  localparam logic [LARGURA-1:0] c_passo = LARGURA'(PASSO);

  // Load wins over increment so a redirect always lands on its target.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= PC_RESET;
    end else if (carrega) begin
      pc <= alvo;
    end else if (incrementa) begin
      pc <= pc + c_passo;
    end
  end

endmodule
`default_nettype wire

// File: rtl/busca_instrucao.sv
`default_nettype none
// ============================================================================
// Module   : busca_instrucao
// Brief    : Instruction fetch unit: owns the PC, fetches over req/ready and
//            delivers words to decode over valid/stall, dropping wrong-path data.
// Revision : 1.0 - initial release
// ============================================================================
module busca_instrucao #(
  parameter int                 LARGURA  = mips_pkg::LARGURA_PALAVRA,
  parameter logic [LARGURA-1:0] PC_RESET = mips_pkg::PC_RESET,
  parameter int                 PASSO    = mips_pkg::PASSO_PC
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               branch_ok,
  input  logic [LARGURA-1:0] alvo_branch,
  input  logic               jump,
  input  logic [LARGURA-1:0] alvo_jump,
  input  logic               stall,
  output logic               mem_req,
  output logic [LARGURA-1:0] mem_addr,
  input  logic               mem_ready,
  input  logic [LARGURA-1:0] mem_dado,
  output logic               instr_valida,
  output logic [LARGURA-1:0] instr,
  output logic [LARGURA-1:0] pc_instr,
  output logic [LARGURA-1:0] pc_mais4,
  output logic               flush
);

  import mips_pkg::*;

  localparam logic [LARGURA-1:0] c_passo = LARGURA'(PASSO);

  estado_busca_t      r_estado;
  estado_busca_t      w_estado_prox;
  logic [LARGURA-1:0] w_pc;
  logic [LARGURA-1:0] w_alvo;
  logic [LARGURA-1:0] r_addr_velho;
  logic               r_descarte;
  logic               r_instr_valida;
  logic               r_flush;
  logic [LARGURA-1:0] r_instr;
  logic [LARGURA-1:0] r_pc_instr;
  logic [LARGURA-1:0] r_pc_mais4;
  logic               w_redirect;
  logic               w_aceito;
  logic               w_captura;

  assign w_redirect = jump | branch_ok;
  assign w_alvo     = alinha_palavra(jump ? alvo_jump : alvo_branch);

  registrador_pc #(
    .LARGURA  (LARGURA),
    .PC_RESET (PC_RESET),
    .PASSO    (PASSO)
  ) u_registrador_pc (
    .clock      (clock),
    .reset      (reset),
    .carrega    (w_redirect),
    .alvo       (w_alvo),
    .incrementa (w_captura),
    .pc         (w_pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= REQUISITA;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  // An in-flight request keeps presenting its original address until accepted.
  always_comb begin
    w_estado_prox = r_estado;
    mem_req       = 1'b0;
    mem_addr      = r_descarte ? r_addr_velho : w_pc;
    w_aceito      = 1'b0;
    w_captura     = 1'b0;
    case (r_estado)
      REQUISITA: begin
        mem_req   = 1'b1;
        w_aceito  = mem_ready;
        // A word still waiting on decode is never overwritten; the fetch repeats.
        w_captura = mem_ready & ~r_descarte & ~w_redirect & ~(r_instr_valida & stall);
        if (w_redirect) begin
          w_estado_prox = REQUISITA;
        end else if (mem_ready && !r_descarte && stall) begin
          w_estado_prox = SEGURA;
        end
      end
      SEGURA: begin
        if (w_redirect || !stall) begin
          w_estado_prox = REQUISITA;
        end
      end
      default: w_estado_prox = REQUISITA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_descarte     <= 1'b0;
      r_addr_velho   <= '0;
      r_instr_valida <= 1'b0;
      r_instr        <= '0;
      r_pc_instr     <= '0;
      r_pc_mais4     <= '0;
      r_flush        <= 1'b0;
    end else begin
      r_flush <= w_redirect;
      if (w_redirect) begin
        r_instr_valida <= 1'b0;
        if (mem_req && !mem_ready) begin
          r_descarte   <= 1'b1;
          r_addr_velho <= mem_addr;
        end else begin
          r_descarte <= 1'b0;
        end
      end else begin
        if (w_aceito) begin
          r_descarte <= 1'b0;
        end
        if (w_captura) begin
          r_instr        <= mem_dado;
          r_pc_instr     <= w_pc;
          r_pc_mais4     <= w_pc + c_passo;
          r_instr_valida <= 1'b1;
        end else if (r_instr_valida && !stall) begin
          r_instr_valida <= 1'b0;
        end
      end
    end
  end

  assign instr_valida = r_instr_valida;
  assign instr        = r_instr;
  assign pc_instr     = r_pc_instr;
  assign pc_mais4     = r_pc_mais4;
  assign flush        = r_flush;

endmodule
`default_nettype wire

// File: tb/tb_busca_instrucao.sv
`default_nettype none
// ============================================================================
// Module   : tb_busca_instrucao
// Brief    : Directed and randomized bench with a consumption scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_busca_instrucao;

  logic        clock;
  logic        reset;
  logic        branch_ok;
  logic [31:0] alvo_branch;
  logic        jump;
  logic [31:0] alvo_jump;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_dado;
  logic        instr_valida;
  logic [31:0] instr;
  logic [31:0] pc_instr;
  logic [31:0] pc_mais4;
  logic        flush;

  int n_chk = 0;
  int n_fail = 0;
  int consumidas = 0;

  logic [31:0] exp_q[$];
  logic [31:0] redir_q[$];

  busca_instrucao dut (
    .clock        (clock),
    .reset        (reset),
    .branch_ok    (branch_ok),
    .alvo_branch  (alvo_branch),
    .jump         (jump),
    .alvo_jump    (alvo_jump),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_dado     (mem_dado),
    .instr_valida (instr_valida),
    .instr        (instr),
    .pc_instr     (pc_instr),
    .pc_mais4     (pc_mais4),
    .flush        (flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] dado_de(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  assign mem_dado = dado_de(mem_addr);

  task automatic chk(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
    n_chk++;
    if (obtido !== esperado) begin
      n_fail++;
      $display("FAIL %s: obtido=%h esperado=%h t=%0t", nome, obtido, esperado, $time);
    end
  endtask

  task automatic ciclo(input bit rst, input bit rdy, input bit stl, input bit jmp,
                       input logic [31:0] aj, input bit br, input logic [31:0] ab);
    @(posedge clock);
    #1;
    reset = rst; mem_ready = rdy; stall = stl;
    jump = jmp; alvo_jump = aj; branch_ok = br; alvo_branch = ab;
    // Youngest redirect target, jump taking priority over branch, word aligned.
    if (jmp || br) redir_q.push_back(jmp ? (aj & ~32'h3) : (ab & ~32'h3));
  endtask

  task automatic reinicia();
    ciclo(1, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] alvo_aleatorio();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 1023));
  endfunction

  // Monitor: protocol rules plus the expected stream of consumed PCs.
  logic        ativo = 1'b0;
  logic        p_reset, p_redir, p_req, p_ready, p_valid, p_stall;
  logic [31:0] p_addr, p_pc_instr, p_instr, e, t;

  always @(negedge clock) begin
    if (ativo) begin
      if (p_reset) begin
        chk("rst_valida", instr_valida, 0);
        chk("rst_flush", flush, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc_instr", pc_instr, 0);
        chk("rst_pc_mais4", pc_mais4, 0);
        chk("rst_mem_req", mem_req, 1);
        chk("rst_mem_addr", mem_addr, 32'h0);
      end else begin
        chk("flush_pulso", flush, p_redir);
        if (p_req && !p_ready) begin
          chk("req_mantido", mem_req, 1);
          chk("addr_estavel", mem_addr, p_addr);
        end
        if (p_valid && p_stall && !p_redir) begin
          chk("stall_valida", instr_valida, 1);
          chk("stall_pc", pc_instr, p_pc_instr);
          chk("stall_instr", instr, p_instr);
        end
      end
      if (instr_valida && !p_reset) begin
        chk("instr_dado", instr, dado_de(pc_instr));
        chk("pc_mais4", pc_mais4, pc_instr + 32'd4);
      end
    end
    t = 32'h0;
    if (jump || branch_ok) begin
      if (redir_q.size() == 0) chk("redir_fila", 0, 1);
      else t = redir_q.pop_front();
    end
    if (reset) begin
      exp_q.delete();
      exp_q.push_back(32'h0);
      ativo = 1'b1;
    end else if (ativo) begin
      if (instr_valida && !stall) begin
        consumidas++;
        if (exp_q.size() == 0) begin
          chk("fila_vazia", pc_instr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pc_consumido", pc_instr, e);
          exp_q.push_back(e + 32'd4);
        end
      end
      if (jump || branch_ok) begin
        exp_q.delete();
        exp_q.push_back(t);
      end
    end
    p_reset = reset; p_redir = jump | branch_ok; p_req = mem_req; p_ready = mem_ready;
    p_valid = instr_valida; p_stall = stall; p_addr = mem_addr;
    p_pc_instr = pc_instr; p_instr = instr;
  end

  bit          r_rst, r_rdy, r_stl, r_jmp, r_br;
  logic [31:0] r_aj, r_ab;

  initial begin
    reset = 1'b1; mem_ready = 1'b0; stall = 1'b0;
    jump = 1'b0; alvo_jump = '0; branch_ok = 1'b0; alvo_branch = '0;

    // Back-to-back sequential fetch
    reinicia(); reinicia();
    ciclo(0, 1, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t1_addr0", mem_addr, 32'h0); chk("t1_valida0", instr_valida, 0);
    ciclo(0, 1, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t1_addr4", mem_addr, 32'h4); chk("t1_valida1", instr_valida, 1); chk("t1_pc0", pc_instr, 32'h0);
    ciclo(0, 1, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t1_addr8", mem_addr, 32'h8); chk("t1_pc4", pc_instr, 32'h4); chk("t1_mais4", pc_mais4, 32'h8);
    ciclo(0, 1, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t1_addrC", mem_addr, 32'hC);

    // Branch while the word at 0x8 is returned
    reinicia();
    ciclo(0, 1, 0, 0, 0, 0, 0);
    ciclo(0, 1, 0, 0, 0, 0, 0);
    ciclo(0, 1, 0, 0, 0, 1, 32'h40); @(negedge clock);
    chk("t2_addr8", mem_addr, 32'h8);
    ciclo(0, 1, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t2_flush", flush, 1); chk("t2_addr40", mem_addr, 32'h40); chk("t2_valida", instr_valida, 0);
    ciclo(0, 1, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t2_flush0", flush, 0); chk("t2_pc40", pc_instr, 32'h40); chk("t2_valida1", instr_valida, 1);

    // Jump during an outstanding request at 0x10
    reinicia();
    repeat (4) ciclo(0, 1, 0, 0, 0, 0, 0);
    ciclo(0, 0, 0, 1, 32'h83, 0, 0); @(negedge clock);
    chk("t3_addr10", mem_addr, 32'h10);
    ciclo(0, 0, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t3_hold1", mem_addr, 32'h10); chk("t3_flush", flush, 1);
    ciclo(0, 0, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t3_hold2", mem_addr, 32'h10);
    ciclo(0, 1, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t3_hold3", mem_addr, 32'h10); chk("t3_valida", instr_valida, 0);
    ciclo(0, 1, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t3_addr80", mem_addr, 32'h80); chk("t3_descartado", instr_valida, 0);
    ciclo(0, 1, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t3_pc80", pc_instr, 32'h80); chk("t3_valida80", instr_valida, 1);

    // Stall for four cycles after 0x4 is delivered
    reinicia();
    ciclo(0, 1, 0, 0, 0, 0, 0);
    ciclo(0, 1, 0, 0, 0, 0, 0);
    ciclo(0, 1, 1, 0, 0, 0, 0); @(negedge clock);
    chk("t4_pc4", pc_instr, 32'h4);
    for (int k = 0; k < 3; k++) begin
      ciclo(0, 1, 1, 0, 0, 0, 0); @(negedge clock);
      chk("t4_req0", mem_req, 0); chk("t4_hold_pc", pc_instr, 32'h4); chk("t4_hold_v", instr_valida, 1);
    end
    ciclo(0, 1, 0, 0, 0, 0, 0);
    ciclo(0, 1, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t4_req1", mem_req, 1); chk("t4_addr8", mem_addr, 32'h8);

    // Wrap of the PC past the top of the address space
    reinicia();
    ciclo(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFE);
    ciclo(0, 1, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t5_addr_topo", mem_addr, 32'hFFFF_FFFC);
    ciclo(0, 1, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t5_addr_wrap", mem_addr, 32'h0); chk("t5_mais4", pc_mais4, 32'h0);

    // Reset during an outstanding request at 0x20
    reinicia();
    ciclo(0, 1, 0, 0, 0, 1, 32'h20);
    ciclo(0, 0, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t6_addr20", mem_addr, 32'h20);
    ciclo(1, 0, 0, 0, 0, 1, 32'h100);
    ciclo(0, 1, 0, 0, 0, 0, 0); @(negedge clock);
    chk("t6_valida", instr_valida, 0); chk("t6_flush", flush, 0); chk("t6_addr0", mem_addr, 32'h0);

    // Randomized traffic
    consumidas = 0;
    for (int i = 0; i < 4000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_rdy = ($urandom_range(0, 9) < 7);
      r_stl = ($urandom_range(0, 3) == 0);
      r_jmp = ($urandom_range(0, 49) == 0);
      r_br  = ($urandom_range(0, 29) == 0);
      r_aj  = alvo_aleatorio();
      r_ab  = alvo_aleatorio();
      ciclo(r_rst, r_rdy, r_stl, r_jmp, r_aj, r_br, r_ab);
    end
    repeat (5) ciclo(0, 1, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("vazao", 32'(consumidas > 200), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
